// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the bit-serial ALU sequencer.
package alu_pkg;

    localparam logic [2:0] OP_PLUS = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_XNOR = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } alu_state_e;

    // Opcodes 5..7 have no slice function and terminate with ERR.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_XNOR);
    endfunction

endpackage

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: feeds an external 1-bit slice LSB first and
// assembles the WIDTH-bit result in a shift register.
//
//   state | meaning
//   IDLE  | waiting for START; slice inputs held at 0
//   RUN   | one operand bit per cycle through the external slice
//   FIN   | one-cycle DONE pulse, RESULT/COUT/ERR valid
module serial_alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [2:0]       OP,
    input  logic [WIDTH-1:0] OPA,
    input  logic [WIDTH-1:0] OPB,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             COUT,
    output logic             ERR,
    output logic [2:0]       S_M,
    output logic             S_A,
    output logic             S_B,
    output logic             S_CI,
    input  logic             S_X,
    input  logic             S_CO
);

    // Counter is sized to hold WIDTH so it can never wrap inside an operation.
    localparam int              CW     = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   C_LAST = CW'(WIDTH - 1);

    alu_state_e       r_state;
    alu_state_e       w_state_nxt;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_err;
    logic             w_is_plus;
    logic             w_last;

    assign w_is_plus = (r_op == OP_PLUS);
    assign w_last    = (r_cnt == C_LAST);

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; START is only looked at in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (START) begin
                    w_state_nxt = op_is_legal(OP) ? RUN : FIN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = FIN;
                end
            end
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: latch on accepted START, shift one bit per RUN cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (START) begin
                        r_op    <= OP;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_carry <= 1'b0;
                        r_cout  <= 1'b0;
                        if (op_is_legal(OP)) begin
                            r_a   <= OPA;
                            r_b   <= OPB;
                            r_err <= 1'b0;
                        end else begin
                            r_a   <= '0;
                            r_b   <= '0;
                            r_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_res <= {S_X, r_res[WIDTH-1:1]};
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_is_plus) begin
                        r_carry <= S_CO;
                    end
                    if (w_last) begin
                        r_cout <= w_is_plus ? S_CO : 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Slice drive is forced to 0 outside RUN; carry-in only matters for plus.
    always_comb begin
        S_M  = 3'd0;
        S_A  = 1'b0;
        S_B  = 1'b0;
        S_CI = 1'b0;
        if (r_state == RUN) begin
            S_M  = r_op;
            S_A  = r_a[0];
            S_B  = r_b[0];
            S_CI = w_is_plus ? r_carry : 1'b0;
        end
    end

    assign BUSY   = (r_state == RUN);
    assign DONE   = (r_state == FIN);
    assign RESULT = r_res;
    assign COUT   = r_cout;
    assign ERR    = r_err;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Scoreboard bench for serial_alu_seq with a behavioural 1-bit slice.
module tb_serial_alu_seq;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         err;
        int           cyc;
    } exp_t;

    logic         CLK, RST_N, START;
    logic [2:0]   OP;
    logic [W-1:0] OPA, OPB;
    logic         BUSY, DONE, COUT, ERR;
    logic [W-1:0] RESULT;
    logic [2:0]   S_M;
    logic         S_A, S_B, S_CI, S_X, S_CO;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_count = 0;
    exp_t sb[$];

    serial_alu_seq #(.WIDTH(W)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .OP(OP), .OPA(OPA), .OPB(OPB),
        .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .COUT(COUT), .ERR(ERR),
        .S_M(S_M), .S_A(S_A), .S_B(S_B), .S_CI(S_CI), .S_X(S_X), .S_CO(S_CO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    // Behavioural 1-bit slice.
    always_comb begin
        logic [1:0] sum;
        sum  = {1'b0, S_A} + {1'b0, S_B} + {1'b0, S_CI};
        S_X  = 1'b0;
        S_CO = 1'b0;
        case (S_M)
            3'd0: begin S_X = sum[0]; S_CO = sum[1]; end
            3'd1: S_X = S_A & S_B;
            3'd2: S_X = S_A | S_B;
            3'd3: S_X = S_A ^ S_B;
            3'd4: S_X = ~(S_A ^ S_B);
            default: begin S_X = 1'b0; S_CO = 1'b0; end
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Word-level reference: whole-operand arithmetic, no bit sequencing.
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.res = '0; e.cout = 1'b0; e.err = 1'b0; e.cyc = 0;
        case (op)
            3'd0: {e.cout, e.res} = {1'b0, a} + {1'b0, b};
            3'd1: e.res = a & b;
            3'd2: e.res = a | b;
            3'd3: e.res = a ^ b;
            3'd4: e.res = ~(a ^ b);
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    // Monitor: every DONE pops one expectation.
    always @(negedge CLK) begin
        if (RST_N && DONE) begin
            done_count++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", 32'(RESULT), 32'(e.res));
                chk("cout", 32'(COUT), 32'(e.cout));
                chk("err", 32'(ERR), 32'(e.err));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input bit push);
        exp_t e;
        @(negedge CLK);
        START = 1'b1; OP = op; OPA = a; OPB = b;
        if (push) begin
            e = model(op, a, b);
            e.cyc = (op <= 3'd4) ? (cyc + 1 + W) : (cyc + 1);
            sb.push_back(e);
        end
        @(posedge CLK);
        #1 START = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        bit seen = 0;
        for (int i = 0; i < 4 * W + 10; i++) begin
            @(posedge CLK);
            if (done_count != d0) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int d0;
        d0 = done_count;
        start_op(op, a, b, 1);
        wait_done(d0);
    endtask

    initial begin
        int d0;
        logic [W-1:0] a, b;
        RST_N = 1'b0; START = 1'b0; OP = 3'd0; OPA = '0; OPB = '0;
        #3;
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_result", 32'(RESULT), 32'd0);
        chk("rst_cout_err", 32'({COUT, ERR}), 32'd0);
        chk("rst_slice", 32'({S_M, S_A, S_B, S_CI}), 32'd0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;

        // Plus 0x5A+0x3C
        do_op(3'd0, 8'h5A, 8'h3C);

        // Plus with full carry chain: check carry-in per bit
        d0 = done_count;
        start_op(3'd0, 8'hFF, 8'h01, 1);
        for (int i = 0; i < W; i++) begin
            @(negedge CLK);
            chk($sformatf("ci_bit%0d", i), 32'(S_CI), (i == 0) ? 32'd0 : 32'd1);
            chk("busy_run", 32'(BUSY), 32'd1);
        end
        wait_done(d0);

        // AND, then XNOR with slice-drive checks
        do_op(3'd1, 8'hF0, 8'h3C);
        d0 = done_count;
        a = 8'hAA; b = 8'h0F;
        start_op(3'd4, a, b, 1);
        for (int i = 0; i < W; i++) begin
            @(negedge CLK);
            chk("xnor_sm", 32'(S_M), 32'd4);
            chk($sformatf("xnor_sab%0d", i), 32'({S_A, S_B, S_CI}), 32'({a[i], b[i], 1'b0}));
        end
        wait_done(d0);

        // Illegal opcode: immediate FIN, no RUN
        d0 = done_count;
        start_op(3'd6, 8'h12, 8'h34, 1);
        @(negedge CLK);
        chk("ill_busy", 32'(BUSY), 32'd0);
        chk("ill_slice", 32'({S_M, S_A, S_B, S_CI}), 32'd0);
        wait_done(d0);

        // START during RUN is ignored
        d0 = done_count;
        start_op(3'd0, 8'h5A, 8'h3C, 1);
        repeat (2) @(negedge CLK);
        start_op(3'd3, 8'h11, 8'h77, 0);
        wait_done(d0);
        repeat (3) @(posedge CLK);
        chk("ignored_start_dones", 32'(done_count - d0), 32'd1);

        // Reset mid-RUN aborts without DONE
        d0 = done_count;
        start_op(3'd0, 8'hC3, 8'h5D, 1);
        repeat (3) @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_done", 32'(DONE), 32'd0);
        chk("abort_outs", 32'({RESULT, COUT, ERR}), 32'd0);
        chk("abort_slice", 32'({S_M, S_A, S_B, S_CI}), 32'd0);
        sb.delete();
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (W + 2) @(negedge CLK);
        chk("abort_no_done", 32'(done_count - d0), 32'd0);
        do_op(3'd0, 8'h01, 8'h01);

        // Random operations, including illegal opcodes
        for (int n = 0; n < 40; n++) begin
            do_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
        end

        repeat (2) @(negedge CLK);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_alu_seq.md
SERIAL_ALU_SEQ -- requirements
Module: serial_alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port START  input  1  request: latch OP/OPA/OPB and begin an operation.
REQ-005 SHALL have port OP  input  3  opcode: 0 plus, 1 AND, 2 OR, 3 XOR, 4 XNOR; 5-7 illegal.
REQ-006 SHALL have port OPA  input  WIDTH  operand A.
REQ-007 SHALL have port OPB  input  WIDTH  operand B.
REQ-008 SHALL have port BUSY  output  1  high from the cycle after an accepted START until DONE.
REQ-009 SHALL have port DONE  output  1  one-cycle pulse: RESULT/COUT/ERR valid.
REQ-010 SHALL have port RESULT  output  WIDTH  final result, held until the next accepted START.
REQ-011 SHALL have port COUT  output  1  final carry (plus only, else 0), held like RESULT.
REQ-012 SHALL have port ERR  output  1  illegal opcode on last operation, held like RESULT.
REQ-013 SHALL have ports S_M (output, 3), S_A, S_B, S_CI (output, 1 each): drive the external 1-bit ALU slice.
REQ-014 SHALL have ports S_X, S_CO (input, 1 each): slice result bit and carry-out, combinational from S_*.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, FIN.
REQ-016 START SHALL be accepted only in IDLE; START in RUN or FIN SHALL be ignored without side effects.
REQ-017 Accepted START with legal OP SHALL latch operands into shift registers, clear the bit counter and the carry register, and enter RUN.
REQ-018 Accepted START with OP 5-7 SHALL enter FIN directly, with RESULT=0, COUT=0, ERR=1, and no RUN cycles.
REQ-019 In RUN, S_M SHALL equal latched OP; S_A/S_B SHALL be the current LSB of the A/B shift registers (bit 0 first).
REQ-020 In RUN, S_CI SHALL be the carry register for plus (0 on bit 0) and 0 for all logic opcodes.
REQ-021 Each RUN edge SHALL shift S_X into the MSB of the result shift register, shift operands right, load the carry register from S_CO (plus only), and increment the counter.
REQ-022 After the WIDTH-th RUN edge, the FSM SHALL enter FIN; RESULT SHALL then hold bit i = slice S_X of cycle i, and COUT the last S_CO (plus) else 0.
REQ-023 FIN SHALL last exactly one cycle with DONE=1, then return to IDLE unconditionally.
REQ-024 Latency: START sampled at edge k with legal OP gives DONE high in the cycle after edge k+WIDTH; illegal OP gives DONE in the cycle after edge k.
REQ-025 Outside RUN, S_M, S_A, S_B, S_CI SHALL be driven 0.
REQ-026 BUSY SHALL be 1 exactly in RUN; DONE exactly in FIN.
REQ-027 The counter SHALL be ceil(log2(WIDTH+1)) bits and never wrap during an operation.

Reset
REQ-028 RST_N low SHALL force IDLE immediately, regardless of the clock.
REQ-029 RST_N low SHALL clear BUSY, DONE, RESULT, COUT, ERR, the counter, the carry register, and the shift registers to 0.
REQ-030 Reset mid-RUN SHALL abort the operation with no DONE pulse; the first START after release SHALL behave as from power-up.

Structure
REQ-031 Opcode constants (OP_PLUS..OP_XNOR) and the FSM state encoding SHALL live in shared package alu_pkg.
REQ-032 The block SHALL be a single module; the 1-bit slice is external and SHALL NOT be instantiated inside it.

Verification (bench supplies a behavioural 1-bit slice on S_*)
REQ-033 Plus, WIDTH=8, OPA=0x5A, OPB=0x3C -> DONE after 8 RUN cycles, RESULT=0x96, COUT=0, ERR=0.
REQ-034 Plus, OPA=0xFF, OPB=0x01 -> RESULT=0x00, COUT=1; S_CI=0 on bit 0 and 1 on bits 1-7.
REQ-035 AND 0xF0,0x3C -> RESULT=0x30; XNOR 0xAA,0x0F -> RESULT=0x5A; COUT=0 for both.
REQ-036 OP=6 -> DONE on the next cycle, ERR=1, RESULT=0, BUSY never high, S_* stay 0.
REQ-037 START pulsed again at RUN cycle 3 with different operands -> ignored; original result returned on schedule.
REQ-038 RST_N low at RUN cycle 4 -> IDLE and all outputs 0 immediately, no DONE; next plus 0x01+0x01 -> RESULT=0x02.
